// File: rtl/sha_digest_target_check_if.sv
// Digest-in / result-out handshake bundle between the hash core, the target
// checker and the nonce controller.
interface sha_digest_target_check_if;
    logic         digest_valid;
    logic         digest_ready;
    logic [255:0] digest;
    logic [31:0]  nonce;
    logic [255:0] target;
    logic         result_valid;
    logic         result_ready;
    logic         result_hit;
    logic [31:0]  result_nonce;

    modport master (
        output digest_valid, digest, nonce, target, result_ready,
        input  digest_ready, result_valid, result_hit, result_nonce
    );

    modport slave (
        input  digest_valid, digest, nonce, target, result_ready,
        output digest_ready, result_valid, result_hit, result_nonce
    );
endinterface

// File: rtl/sha_digest_target_check.sv
// Compares a final SHA-256 digest against the difficulty target one 32-bit word
// per cycle (most significant word first) and reports hit/miss with its nonce.
module sha_digest_target_check #(
    parameter int HIT_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sha_digest_target_check_if.slave bus,
    output logic [HIT_CNT_W-1:0] hit_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        REPORT  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           k_q, k_d;
    logic [255:0]         dig_q, tgt_q;
    logic [31:0]          nonce_q;
    logic                 rdy_q, rv_q, hit_q;
    logic [31:0]          rnonce_q;
    logic [HIT_CNT_W-1:0] hc_q;
    logic [31:0]          w, t;
    logic                 capture, decide, hit_d;

    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [HIT_CNT_W-1:0] sat_inc(input logic [HIT_CNT_W-1:0] c);
        return (&c) ? c : c + {{(HIT_CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // H_k sits at digest word (7-k) while T_k sits at target word k
    assign w       = bswap32(dig_q[{~k_q, 5'b0} +: 32]);
    assign t       = tgt_q[{k_q, 5'b0} +: 32];
    assign capture = bus.digest_valid & rdy_q;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        decide  = 1'b0;
        hit_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d = COMPARE;
                    k_d     = 3'd7;
                end
            end
            COMPARE: begin
                if (w < t) begin
                    decide = 1'b1;
                    hit_d  = 1'b1;
                end else if (w > t) begin
                    decide = 1'b1;
                end else if (k_q == 3'd0) begin
                    decide = 1'b1;
                    hit_d  = 1'b1;
                end else begin
                    k_d = k_q - 3'd1;
                end
                if (decide) state_d = REPORT;
            end
            REPORT: begin
                if (rv_q && bus.result_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and result registers; everything visible at the ports is registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            k_q      <= 3'd7;
            rdy_q    <= 1'b0;
            rv_q     <= 1'b0;
            hit_q    <= 1'b0;
            rnonce_q <= 32'd0;
            hc_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            rdy_q   <= (state_d == IDLE);
            rv_q    <= (state_d == REPORT);
            if (decide) begin
                hit_q    <= hit_d;
                rnonce_q <= nonce_q;
                if (hit_d) hc_q <= sat_inc(hc_q);
            end
        end
    end

    // Operand capture registers carry data only
    always_ff @(posedge clk) begin
        if (capture) begin
            dig_q   <= bus.digest;
            tgt_q   <= bus.target;
            nonce_q <= bus.nonce;
        end
    end

    assign bus.digest_ready = rdy_q;
    assign bus.result_valid = rv_q;
    assign bus.result_hit   = hit_q;
    assign bus.result_nonce = rnonce_q;
    assign hit_count        = hc_q;

endmodule

// File: tb/tb_sha_digest_target_check.sv
// Scoreboard bench for sha_digest_target_check: directed digests with
// hand-computed outcomes, checked by an independent result monitor.
module tb_sha_digest_target_check;

    localparam int HCW    = 2;
    localparam int HC_MAX = (1 << HCW) - 1;

    typedef struct {
        logic        hit;
        logic [31:0] nonce;
        int          cap;
        int          lat;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [HCW-1:0] hit_count;
    int             cyc = 0;
    int             checks = 0;
    int             errors = 0;
    int             exp_hc = 0;
    exp_t           sb[$];
    logic           prev_rv = 1'b0;

    sha_digest_target_check_if bus();

    sha_digest_target_check #(.HIT_CNT_W(HCW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .hit_count (hit_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Target words T7..T0 and hash-integer variants (hash word k = [k*32 +: 32])
    localparam logic [255:0] TGT   = 256'h00000000_FFFFFFFF_12345678_9ABCDEF0_0000FFFF_80000000_00000001_00000006;
    localparam logic [255:0] W_EQ  = TGT;
    localparam logic [255:0] W_D5  = 256'h00000000_FFFFFFFF_12345678_9ABCDEF0_0000FFFF_80000000_00000001_00000005;
    localparam logic [255:0] W_D7  = 256'h00000000_FFFFFFFF_12345678_9ABCDEF0_0000FFFF_80000000_00000001_00000007;
    localparam logic [255:0] W_K4  = 256'h00000000_FFFFFFFF_12345678_9ABCDEF1_00000000_00000000_00000000_00000000;
    localparam logic [255:0] W_K3  = 256'h00000000_FFFFFFFF_12345678_9ABCDEF0_0000FFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF;
    localparam logic [255:0] TGT2  = 256'h80000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000;
    localparam logic [255:0] W_E7  = 256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;

    function automatic logic [31:0] bs(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // Digest layout whose hash-integer words equal w
    function automatic logic [255:0] mk(input logic [255:0] w);
        logic [255:0] d;
        for (int k = 0; k < 8; k++) d[(7-k)*32 +: 32] = bs(w[k*32 +: 32]);
        return d;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic send(input logic [255:0] d, input logic [255:0] t, input logic [31:0] n,
                        input logic hit, input int lat, input bit push);
        int guard = 0;
        @(negedge clk);
        bus.digest = d; bus.target = t; bus.nonce = n; bus.digest_valid = 1'b1;
        while (!bus.digest_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.digest_ready) begin
            chk("capture_timeout", 64'(bus.digest_ready), 64'd1);
            bus.digest_valid = 1'b0;
            return;
        end
        if (push) begin
            sb.push_back('{hit: hit, nonce: n, cap: cyc + 1, lat: lat});
            if (hit && exp_hc < HC_MAX) exp_hc++;
        end
        @(negedge clk);
        bus.digest_valid = 1'b0;
        bus.digest = ~d; bus.target = ~t; bus.nonce = ~n;
    endtask

    task automatic drain(input string nm);
        int guard = 0;
        while ((sb.size() != 0 || bus.result_valid) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk({nm, "_drained"}, 64'(sb.size()), 64'd0);
        #1;
        chk({nm, "_hit_count"}, 64'(hit_count), 64'(exp_hc));
    endtask

    // Result monitor: compares every presented result against the scoreboard head
    always begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            prev_rv = 1'b0;
        end else begin
            if (bus.result_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 64'(bus.result_valid), 64'd0);
                end else begin
                    if (!prev_rv) chk("latency", 64'(cyc - sb[0].cap), 64'(sb[0].lat));
                    chk("result_hit", 64'(bus.result_hit), 64'(sb[0].hit));
                    chk("result_nonce", 64'(bus.result_nonce), 64'(sb[0].nonce));
                    if (bus.result_ready) void'(sb.pop_front());
                end
            end
            prev_rv = bus.result_valid && !bus.result_ready;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.digest_valid = 1'b0;
        bus.digest       = '0;
        bus.target       = '0;
        bus.nonce        = '0;
        bus.result_ready = 1'b1;

        // Reset, with a digest offered while reset is held
        repeat (2) @(negedge clk);
        bus.digest_valid = 1'b1;
        bus.digest = mk(W_EQ); bus.target = TGT; bus.nonce = 32'h0BADF00D;
        @(negedge clk);
        #1;
        chk("rst_digest_ready", 64'(bus.digest_ready), 64'd0);
        chk("rst_result_valid", 64'(bus.result_valid), 64'd0);
        bus.digest_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rel_digest_ready", 64'(bus.digest_ready), 64'd1);
        chk("rel_result_valid", 64'(bus.result_valid), 64'd0);
        chk("rel_hit_count", 64'(hit_count), 64'd0);
        chk("rel_result_nonce", 64'(bus.result_nonce), 64'd0);
        repeat (10) @(negedge clk);

        // Directed vectors, consumer always ready
        send({224'h0, 32'h00000001}, 256'h0, 32'hDEADBEEF, 1'b0, 1, 1'b1);
        drain("early_miss");
        send(mk(W_D5), TGT, 32'h00000011, 1'b1, 8, 1'b1);
        drain("deep_hit");
        send(mk(W_EQ), TGT, 32'h00000022, 1'b1, 8, 1'b1);
        drain("exact_eq");
        send(mk(W_D7), TGT, 32'h00000033, 1'b0, 8, 1'b1);
        drain("deep_miss");
        send(mk(W_K4), TGT, 32'h00000044, 1'b0, 4, 1'b1);
        drain("mid_miss");
        send(mk(W_K3), TGT, 32'h00000055, 1'b1, 5, 1'b1);
        drain("mid_hit");
        send(mk(W_E7), TGT2, 32'h00000066, 1'b1, 1, 1'b1);
        drain("early_hit");

        // Back-to-back at full rate
        send(mk(W_E7), TGT2, 32'h00000077, 1'b1, 1, 1'b1);
        send({224'h0, 32'h00000001}, 256'h0, 32'h00000088, 1'b0, 1, 1'b1);
        drain("back_to_back");

        // Backpressure with a second digest waiting upstream
        bus.result_ready = 1'b0;
        send(mk(W_D5), TGT, 32'h11111111, 1'b1, 8, 1'b1);
        begin
            int guard = 0;
            while (!bus.result_valid && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            chk("bp_result_valid_rise", 64'(bus.result_valid), 64'd1);
        end
        fork
            send({224'h0, 32'h00000001}, 256'h0, 32'h22222222, 1'b0, 1, 1'b1);
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    #1;
                    chk("bp_result_valid", 64'(bus.result_valid), 64'd1);
                    chk("bp_digest_ready", 64'(bus.digest_ready), 64'd0);
                end
                bus.result_ready = 1'b1;
            end
        join
        drain("backpressure");

        // Reset in the middle of a compare (k = 4)
        send(mk(W_EQ), TGT, 32'h33333333, 1'b1, 8, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_result_valid", 64'(bus.result_valid), 64'd0);
        chk("abort_digest_ready", 64'(bus.digest_ready), 64'd0);
        chk("abort_hit_count", 64'(hit_count), 64'd0);
        chk("abort_result_nonce", 64'(bus.result_nonce), 64'd0);
        chk("abort_result_hit", 64'(bus.result_hit), 64'd0);
        exp_hc = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        #1;
        chk("post_abort_result_valid", 64'(bus.result_valid), 64'd0);

        // Saturation: five hits on a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            send(mk(W_D5), TGT, 32'hA0000000 + 32'(i), 1'b1, 8, 1'b1);
            drain("sat");
        end
        chk("sat_final", 64'(hit_count), 64'd3);
        send(mk(W_D7), TGT, 32'hB0000000, 1'b0, 8, 1'b1);
        drain("sat_miss_hold");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
